put_hdisk_data: RTL

- ATA/IDE PIO data-out transmitter: the write-direction counterpart of the disk read-capture path.
- Fetches 16-bit words from a 32-entry sector staging RAM and drives them onto DD with programmable DIOW- timing, honouring IORDY wait-state stretching.
- Sits between the write staging RAM and the IDE pad ring. The command/taskfile sequencer owns IDE_w_en and Word_cnt.

---
 rtl/put_hdisk_data.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/put_hdisk_data.sv
// ---------------------------------------------------------------------------
// put_hdisk_data
//
// ATA/IDE PIO data-out transmitter. Fetches 16-bit words from the 32-entry
// write staging RAM and presents them on the DD pad with a programmable
// DIOW- strobe. The low phase of the strobe is stretched while the device
// holds IORDY low, and a burst is abandoned if that stretch lasts too long.
//
// Ports
//   clk        in   1   system clock
//   pRST       in   1   asynchronous reset, active high
//   IDE_w_en   in   1   burst request level (synchronised here)
//   Word_cnt   in   6   words in the burst, sampled on the start edge
//   IORDY      in   1   device ready (synchronised here)
//   RAM_RDATA  in  16   staging RAM read data, one cycle after RAM_RADDR
//   RAM_RADDR  out  5   staging RAM read address
//   DD_out     out 16   data to the DD pad
//   DD_oe      out  1   DD pad output enable
//   DIOW_n     out  1   IDE write strobe, active low
//   Busy       out  1   high from start through the Done/Err cycle
//   Done       out  1   one-cycle pulse on burst completion
//   Err        out  1   one-cycle pulse on IORDY timeout abort
//
// State  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for a rising edge of the synchronised burst request
// FETCH  | RAM_RADDR presents the current word address
// LOAD   | RAM_RDATA captured into DD_out at the end of the cycle
// SETUP  | DD driven, DIOW- high, T_SETUP cycles
// PULSE  | DIOW- low, T_PULSE cycles then held while IORDY is low
// HOLD   | DIOW- high, DD still driven, T_HOLD cycles
// RECOV  | DD released, T_RECOV cycles; advances to the next word
// FIN    | Done pulse, back to IDLE
// ---------------------------------------------------------------------------
module put_hdisk_data #(
    parameter int T_SETUP     = 3,
    parameter int T_PULSE     = 8,
    parameter int T_HOLD      = 2,
    parameter int T_RECOV     = 6,
    parameter int T_IORDY_MAX = 1024
) (
    input  logic        clk,
    input  logic        pRST,
    input  logic        IDE_w_en,
    input  logic [5:0]  Word_cnt,
    input  logic        IORDY,
    input  logic [15:0] RAM_RDATA,
    output logic [4:0]  RAM_RADDR,
    output logic [15:0] DD_out,
    output logic        DD_oe,
    output logic        DIOW_n,
    output logic        Busy,
    output logic        Done,
    output logic        Err
);

    // One shared phase timer covers SETUP/PULSE/HOLD/RECOV, so it is sized
    // for the longest of them.
    localparam int T_MAX_AB  = (T_SETUP > T_PULSE) ? T_SETUP : T_PULSE;
    localparam int T_MAX_CD  = (T_HOLD > T_RECOV) ? T_HOLD : T_RECOV;
    localparam int T_MAX     = (T_MAX_AB > T_MAX_CD) ? T_MAX_AB : T_MAX_CD;
    localparam int TW        = $clog2(T_MAX + 1);
    localparam int WW        = $clog2(T_IORDY_MAX + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        SETUP = 3'd3,
        PULSE = 3'd4,
        HOLD  = 3'd5,
        RECOV = 3'd6,
        FIN   = 3'd7
    } state_t;

    state_t          state;
    state_t          state_nx;

    logic            ide_s1;
    logic            ide_s2;
    logic            ide_s3;
    logic            iordy_s1;
    logic            iordy_s2;

    logic [TW-1:0]   timer;
    logic [TW-1:0]   timer_nx;
    logic [WW-1:0]   wait_cnt;
    logic [WW-1:0]   wait_nx;
    logic [5:0]      words_left;
    logic [5:0]      words_nx;
    logic [4:0]      raddr_nx;
    logic [15:0]     dd_nx;
    logic            abort;
    logic            start;

    // -----------------------------------------------------------------------
    // Input synchronisers. The third request flop exists only for edge
    // detection; the FSM itself looks at the level on ide_s2.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge pRST) begin
        if (pRST) begin
            ide_s1   <= 1'b0;
            ide_s2   <= 1'b0;
            ide_s3   <= 1'b0;
            iordy_s1 <= 1'b0;
            iordy_s2 <= 1'b0;
        end else begin
            ide_s1   <= IDE_w_en;
            ide_s2   <= ide_s1;
            ide_s3   <= ide_s2;
            iordy_s1 <= IORDY;
            iordy_s2 <= iordy_s1;
        end
    end

    // Edges arriving outside IDLE are dropped: a request that is still high
    // after a burst must be lowered and raised again to start another.
    assign start = (state == IDLE) && ide_s2 && !ide_s3;

    // -----------------------------------------------------------------------
    // Next-state and datapath update
    // -----------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        timer_nx = timer;
        wait_nx  = wait_cnt;
        words_nx = words_left;
        raddr_nx = RAM_RADDR;
        dd_nx    = DD_out;
        abort    = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    raddr_nx = 5'd0;
                    wait_nx  = '0;
                    if (Word_cnt == 6'd0) begin
                        words_nx = 6'd0;
                        state_nx = FIN;
                    end else begin
                        // The staging RAM only holds one 32-word sector.
                        words_nx = (Word_cnt > 6'd32) ? 6'd32 : Word_cnt;
                        state_nx = FETCH;
                    end
                end
            end

            FETCH: begin
                state_nx = LOAD;
            end

            LOAD: begin
                dd_nx    = RAM_RDATA;
                timer_nx = TW'(T_SETUP - 1);
                state_nx = SETUP;
            end

            SETUP: begin
                if (timer == '0) begin
                    timer_nx = TW'(T_PULSE - 1);
                    wait_nx  = '0;
                    state_nx = PULSE;
                end else begin
                    timer_nx = timer - TW'(1);
                end
            end

            PULSE: begin
                // The minimum width always runs out first; only then does
                // IORDY get a say, and only then does the wait counter run.
                if (timer != '0) begin
                    timer_nx = timer - TW'(1);
                end else if (iordy_s2) begin
                    timer_nx = TW'(T_HOLD - 1);
                    state_nx = HOLD;
                end else if (wait_cnt == WW'(T_IORDY_MAX)) begin
                    abort    = 1'b1;
                    state_nx = IDLE;
                end else begin
                    wait_nx = wait_cnt + WW'(1);
                end
            end

            HOLD: begin
                if (timer == '0) begin
                    timer_nx = TW'(T_RECOV - 1);
                    state_nx = RECOV;
                end else begin
                    timer_nx = timer - TW'(1);
                end
            end

            RECOV: begin
                if (timer == '0) begin
                    raddr_nx = RAM_RADDR + 5'd1;
                    words_nx = words_left - 6'd1;
                    // A dropped request only takes effect here, so a strobe
                    // already under way always finishes cleanly.
                    if ((words_left > 6'd1) && ide_s2) begin
                        state_nx = FETCH;
                    end else begin
                        state_nx = FIN;
                    end
                end else begin
                    timer_nx = timer - TW'(1);
                end
            end

            FIN: begin
                state_nx = IDLE;
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge pRST) begin
        if (pRST) begin
            state      <= IDLE;
            timer      <= '0;
            wait_cnt   <= '0;
            words_left <= 6'd0;
            RAM_RADDR  <= 5'd0;
            DD_out     <= 16'd0;
        end else begin
            state      <= state_nx;
            timer      <= timer_nx;
            wait_cnt   <= wait_nx;
            words_left <= words_nx;
            RAM_RADDR  <= raddr_nx;
            DD_out     <= dd_nx;
        end
    end

    // -----------------------------------------------------------------------
    // Pad and status outputs are registered from the next state so they
    // line up exactly with the state they describe and cannot glitch.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge pRST) begin
        if (pRST) begin
            DIOW_n <= 1'b1;
            DD_oe  <= 1'b0;
            Busy   <= 1'b0;
            Done   <= 1'b0;
            Err    <= 1'b0;
        end else begin
            DIOW_n <= (state_nx != PULSE);
            DD_oe  <= (state_nx == SETUP) || (state_nx == PULSE) ||
                      (state_nx == HOLD);
            // The abort cycle is already IDLE, yet Busy must still cover it.
            Busy   <= (state_nx != IDLE) || abort;
            Done   <= (state_nx == FIN);
            Err    <= abort;
        end
    end

endmodule
